wishbone_responder: RTL and testbench
=====================================

WISHBONE_RESPONDER -- requirements
Module: wishbone_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 6; byte address width; word index is wb_adr_i[ADDR_WIDTH-1:2].
REQ-002 Parameter NUM_REGS, default 12; implemented words, indices 0..NUM_REGS-1.
REQ-003 Parameter WAIT_STATES, default 2, range 0..15; idle cycles inserted before each response.
REQ-004 Parameter ID_VALUE, default 32'h5742_0001; read-only identification word.
REQ-005 The block has one clock; reset is asynchronous and active-high.
REQ-006 wb_clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 wb_rst_i  input  1  asynchronous active-high reset.
REQ-008 wb_adr_i  input  ADDR_WIDTH  byte address.
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_dat_o  output  32  read data, valid only while wb_ack_o=1.
REQ-011 wb_sel_i  input  4  byte-lane enables; bit n covers [8n+7:8n].
REQ-012 wb_we_i  input  1  1=write, 0=read.
REQ-013 wb_cyc_i, wb_stb_i  input  1 each  bus cycle and strobe.
REQ-014 wb_ack_o  output  1  normal termination, one-cycle pulse.
REQ-015 wb_err_o  output  1  error termination, one-cycle pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: cyc&stb=1 latches adr/dat/sel/we and goes to WAIT if WAIT_STATES>0, else to RESP.
REQ-018 WAIT: a 4-bit counter counts WAIT_STATES cycles, then goes to RESP; cyc=0 in WAIT aborts to IDLE with no write and no response.
REQ-019 RESP: exactly one of wb_ack_o/wb_err_o=1 for one cycle, then IDLE unconditionally.
REQ-020 Latency: response asserted WAIT_STATES+1 cycles after the first cycle cyc&stb is sampled high; a transfer held across back-to-back requests has one IDLE cycle between responses.
REQ-021 Word index 0..NUM_REGS-3: read/write RAM registers, reset 0.
REQ-022 Word index NUM_REGS-2: read-only transfer counter, reset 0, +1 on every ack (not err), wraps 32'hFFFF_FFFF->0.
REQ-023 Word index NUM_REGS-1: read-only ID_VALUE.
REQ-024 Writes commit on the edge entering RESP, only lanes with sel bit=1; sel=4'b0000 write acks with no change.
REQ-025 Error (err, no ack, no state change) for: index >= NUM_REGS; write to index NUM_REGS-2 or NUM_REGS-1.
REQ-026 Reads return the full 32-bit word regardless of sel; wb_dat_o=0 whenever wb_ack_o=0.
REQ-027 Request inputs changing after the IDLE sample SHALL NOT affect the transfer in progress.
REQ-028 The counter increments in the ack cycle; a read of the counter returns the value before its own increment.

Reset
REQ-029 wb_rst_i=1 SHALL immediately force state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, all RAM registers 0, transfer counter 0.
REQ-030 Reset mid-transfer discards the transfer with no write and no response; first sample is on the first rising edge after wb_rst_i falls.

Structure
REQ-031 Package wishbone_responder_pkg SHALL hold the state enum, ID_VALUE default, and a byte-lane merge function (old, new, sel -> merged).
REQ-032 No sub-module; the register bank is a flat array inside wishbone_responder.

Verification
REQ-033 Write 32'hDEAD_BEEF to 0x04, sel=4'hF, WAIT_STATES=2 -> ack exactly 3 cycles after first sample; read 0x04 -> 32'hDEAD_BEEF.
REQ-034 Write 32'h1122_3344 to 0x08 sel=4'hF, then 32'hAABB_CCDD sel=4'b0101 -> read 0x08 returns 32'h11BB_33DD.
REQ-035 Read 0x2C (index 11) -> 32'h5742_0001 with ack; write 0x2C, or read 0x30 (index 12) -> err pulse, no ack, registers unchanged.
REQ-036 Five acked transfers plus one err after reset -> read of 0x28 returns 5.
REQ-037 Drop cyc one cycle into WAIT for a write of 32'h0000_00FF to 0x00 -> no ack/err; read 0x00 -> 0.
REQ-038 Assert wb_rst_i mid-WAIT after writing 32'h1234_5678 to 0x0C -> no response; read 0x0C -> 0.

Source files
------------

// File: rtl/wishbone_responder_pkg.sv
// wishbone_responder_pkg: FSM states, default ID word and byte-lane merge helper
package wishbone_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] ID_DEFAULT = 32'h5742_0001;
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/wishbone_responder.sv
// wishbone_responder: wait-stated Wishbone slave with RAM words, transfer counter and ID word
module wishbone_responder
  import wishbone_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS = 12,
  parameter int WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o
);
  localparam int IW = ADDR_WIDTH - 2;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [IW-1:0] adr, c_adr;
  logic [31:0] dat, c_dat, xfer, idx, rd;
  logic [3:0] sel, c_sel;
  logic we, c_we, req, to_resp, bad;
  logic [31:0] regs [NUM_REGS-2];
  assign req = wb_cyc_i & wb_stb_i;
  // With zero wait states the response is decided in the sampling cycle, so decode the live request there
  always_comb begin
    c_adr = state == IDLE ? wb_adr_i[ADDR_WIDTH-1:2] : adr;
    c_dat = state == IDLE ? wb_dat_i : dat;
    c_sel = state == IDLE ? wb_sel_i : sel;
    c_we = state == IDLE ? wb_we_i : we;
    idx = 32'(c_adr);
    state_n = state == IDLE ? (req ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE)
            : state == WAIT ? (!wb_cyc_i ? IDLE : cnt == 4'(WAIT_STATES - 1) ? RESP : WAIT)
            : IDLE;
    to_resp = state_n == RESP;
    bad = idx >= NUM_REGS || (c_we && idx >= NUM_REGS - 2);
    rd = idx < NUM_REGS - 2 ? regs[c_adr] : idx == NUM_REGS - 2 ? xfer : ID_VALUE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
      adr <= '0;
      dat <= '0;
      sel <= '0;
      we <= 1'b0;
      xfer <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      for (int i = 0; i < NUM_REGS - 2; i++) regs[i] <= '0;
    end else begin
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && req) begin
        adr <= wb_adr_i[ADDR_WIDTH-1:2];
        dat <= wb_dat_i;
        sel <= wb_sel_i;
        we <= wb_we_i;
      end
      wb_ack_o <= to_resp && !bad;
      wb_err_o <= to_resp && bad;
      wb_dat_o <= (to_resp && !bad && !c_we) ? rd : 32'd0;
      if (to_resp && !bad && c_we) regs[c_adr] <= merge(regs[c_adr], c_dat, c_sel);
      // Counter moves at the end of the ack cycle so a read of it reports the pre-increment value
      if (state == RESP && wb_ack_o) xfer <= xfer + 32'd1;
    end
  end
endmodule

// File: tb/tb_wishbone_responder.sv
// tb_wishbone_responder: directed-vector check of wishbone_responder with default parameters
module tb_wishbone_responder;
  logic clk = 0, rst = 1;
  logic [5:0] adr = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic [3:0] sel = 0;
  logic we = 0, cyc = 0, stb = 0, ack, err;
  int n_vec = 0, n_bad = 0;
  wishbone_responder dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input bit scr,
                     output logic ak, output logic er, output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk);
    lat = 1;
    if (scr) begin
      #1;
      adr = a + 6'd4; dat_i = ~d; sel = 4'hF;
    end
    @(negedge clk);
    while (!(ack | err) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ak = ack; er = err; rdat = dat_o;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("pulse", {30'd0, ack, err}, 32'd0);
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input bit scr = 0);
    logic ak, er; logic [31:0] r; int l;
    bus(1'b1, a, d, s, scr, ak, er, r, l);
    chk("wr_ack", {30'd0, ak, er}, 32'd2);
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] exp);
    logic ak, er; logic [31:0] r; int l;
    bus(1'b0, a, 32'd0, 4'h0, 1'b0, ak, er, r, l);
    chk("rd_ack", {30'd0, ak, er}, 32'd2);
    chk("rd_data", r, exp);
  endtask
  task automatic bad_acc(input logic w, input logic [5:0] a);
    logic ak, er; logic [31:0] r; int l;
    bus(w, a, 32'hFFFF_FFFF, 4'hF, 1'b0, ak, er, r, l);
    chk("err_resp", {30'd0, ak, er}, 32'd1);
    chk("err_data", r, 32'd0);
  endtask
  initial begin
    logic ak, er; logic [31:0] r; int l; bit seen;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    @(posedge clk); #1 rst = 0;
    bus(1'b1, 6'h04, 32'hDEAD_BEEF, 4'hF, 1'b0, ak, er, r, l);
    chk("w04_ack", {30'd0, ak, er}, 32'd2);
    chk("w04_lat", l, 32'd3);
    rd(6'h04, 32'hDEAD_BEEF);
    wr(6'h08, 32'h1122_3344, 4'hF);
    wr(6'h08, 32'hAABB_CCDD, 4'b0101);
    rd(6'h08, 32'h11BB_33DD);
    bad_acc(1'b1, 6'h2C);
    rd(6'h28, 32'd5);
    rd(6'h2C, 32'h5742_0001);
    bad_acc(1'b0, 6'h30);
    bad_acc(1'b1, 6'h28);
    rd(6'h28, 32'd7);
    rd(6'h04, 32'hDEAD_BEEF);
    wr(6'h0C, 32'hCAFE_F00D, 4'hF);
    wr(6'h0C, 32'h0000_0000, 4'h0);
    rd(6'h0C, 32'hCAFE_F00D);
    wr(6'h24, 32'h0000_0099, 4'hF);
    rd(6'h24, 32'h0000_0099);
    wr(6'h10, 32'h0A0B_0C0D, 4'hF, 1'b1);
    rd(6'h10, 32'h0A0B_0C0D);
    rd(6'h14, 32'd0);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 6'h00; dat_i = 32'h0000_00FF; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack | err;
    end
    chk("abort_resp", {31'd0, seen}, 32'd0);
    rd(6'h00, 32'd0);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 6'h0C; dat_i = 32'h1234_5678; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_out", {dat_o[29:0], ack, err}, 32'd0);
    @(posedge clk); #1;
    rst = 0; cyc = 0; stb = 0; we = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack | err;
    end
    chk("rst_resp", {31'd0, seen}, 32'd0);
    rd(6'h0C, 32'd0);
    rd(6'h04, 32'd0);
    rd(6'h28, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
